ssd_time_monitor: RTL and testbench
===================================

Name: ssd_time_monitor

Overview:
Receive-side checker for the seven-digit seven-segment timer output (day, hour_h/l, min_h/l, sec_h/l).
- Decodes each segment bus back to BCD and checks every digit for a legal glyph and a legal range.
- Confirms that each change of the displayed time is exactly one second later than the previous time, with all carries applied.
- Counts confirmed ticks.
- Sits beside the timer in system benches and on-chip self-test; its inputs connect directly to the timer's ssd outputs.

Parameters:
CNT_W, 32, width of elapsed_sec; the counter saturates at all-ones.
DAY_MAX, 9, last legal day value; the day digit wraps from DAY_MAX to 0.

Ports:
clk  in  1  clock source
rst_n  in  1  active-low asynchronous reset
clr_err  in  1  synchronous clear of the sticky seq_err; active high
ssd_day  in  7  segment bus, day digit (bit6=a ... bit0=g)
ssd_hour_h  in  7  segment bus, hour tens
ssd_hour_l  in  7  segment bus, hour units
ssd_min_h  in  7  segment bus, minute tens
ssd_min_l  in  7  segment bus, minute units
ssd_sec_h  in  7  segment bus, second tens
ssd_sec_l  in  7  segment bus, second units
bcd_time  out  28  decoded digits {day,hour_h,hour_l,min_h,min_l,sec_h,sec_l}, 4 bits each
time_vld  out  1  bcd_time holds a legal frame
tick  out  1  one-cycle pulse when a correct +1 s successor is confirmed
glyph_err  out  1  one-cycle pulse when any bus carries a non-digit pattern
range_err  out  1  one-cycle pulse for a legal glyph out of range
seq_err  out  1  sticky flag: the time changed to something other than its successor
locked  out  1  state is LOCK
elapsed_sec  out  CNT_W  count of confirmed ticks since reset

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0 and the state is IDLE.
- Glyph encoding is fixed: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. Any other pattern is illegal and decodes to 4'hF.
- Pipeline stage 1: register all seven buses every cycle (capture register).
- Pipeline stage 2: decode, check, compare; register all outputs.
- Latency: an input change present before edge N is reflected in bcd_time, flags and tick at edge N+1. Back-to-back changes on every cycle are fully supported.
- Range rules:
  - sec_h and min_h must be ≤ 5.
  - hour_h must be ≤ 2; if hour_h = 2 then hour_l must be ≤ 3.
  - day must be ≤ DAY_MAX.
- Frame legal = no glyph error AND no range error. time_vld = 1 only when the last frame was legal.
- Successor function succ(T) is a +1 s increment:
  - sec_l 9→0 carries into sec_h; sec_h 5→0 carries into min_l.
  - The minute digits follow the same rules.
  - Hour 23→00 carries into day; day DAY_MAX→0.
- Prev register P holds the last legal frame.
- State machine IDLE / LOCK / FAULT:
  - IDLE: on a legal frame, load P and go to LOCK. No tick and no compare.
  - LOCK, frame equals P: hold, no action.
  - LOCK, frame equals succ(P): tick=1, elapsed_sec+1 (saturating), load P.
  - LOCK, legal frame neither P nor succ(P): seq_err set, load P, go to FAULT.
  - FAULT: behaves as LOCK (ticks continue, P keeps tracking). It returns to LOCK when seq_err is cleared.
  - Illegal frame in any state: pulse glyph_err and/or range_err, leave P unchanged, go to IDLE.
  - In FAULT, the seq_err flag stays set after this move to IDLE.
- clr_err=1: seq_err←0 on the next edge. If the same edge also detects a new sequence error, the detection wins and seq_err stays 1.
- locked = (state == LOCK).
- tick, glyph_err and range_err are single-cycle and never stretch.
- elapsed_sec is not cleared by clr_err; only rst_n clears it.
- Reset mid-operation: asynchronous clear of every register, including the capture register. The first frame after release starts in IDLE and gives no tick.

Decomposition:
- Shared package ssd_pkg:
  - ten glyph constants (SSD_ZERO..SSD_NINE)
  - SSD_ILLEGAL = 4'hF
  - state encodings ST_IDLE/ST_LOCK/ST_FAULT
  - digit limit constants (5, 2, 3)
- Sub-module ssd_glyph_dec: combinational, 7-bit in, 4-bit digit plus illegal flag out. Instantiated seven times.
- The succ() increment chain and the range checks stay in the top module.

Test Plan:
- Reset then drive the legal frame 0 00:00:00 held for 3 cycles:
  - locked=1 two cycles after the first capture
  - tick=0 throughout
  - elapsed_sec=0
- Lock on 3 23:59:58, then 3 23:59:59, then 4 00:00:00 on consecutive cycles:
  - two tick pulses
  - elapsed_sec=2
  - bcd_time=28'h4000000
  - seq_err=0
- Locked at 1 10:15:30, then drive 1 10:15:32:
  - seq_err=1 and stays set
  - state FAULT
  - next frame 1 10:15:33 produces tick=1
  - clr_err=1 clears seq_err and locked returns to 1
- Drive ssd_min_l=7'b0000001:
  - glyph_err pulses once
  - time_vld=0
  - locked=0
  - restoring a legal frame relocks with no tick
- Drive hour 2,4 (legal glyphs):
  - range_err=1 for one cycle
  - bcd_time shows hour digits 2,4
  - time_vld=0
- Day 9 23:59:59 → 0 00:00:00 with DAY_MAX=9:
  - tick=1
  - assert rst_n low mid-stream: all outputs 0 asynchronously; no tick on the first frame after release.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants for the seven-segment time monitor.
//   - glyph patterns for digits 0..9 (bit6 = segment a ... bit0 = segment g)
//   - code returned for an unrecognised glyph
//   - monitor state encodings
//   - per-digit upper limits used by the range checks
package ssd_pkg;

  localparam logic [6:0] SSD_ZERO  = 7'b1111110;
  localparam logic [6:0] SSD_ONE   = 7'b0110000;
  localparam logic [6:0] SSD_TWO   = 7'b1101101;
  localparam logic [6:0] SSD_THREE = 7'b1111001;
  localparam logic [6:0] SSD_FOUR  = 7'b0110011;
  localparam logic [6:0] SSD_FIVE  = 7'b1011011;
  localparam logic [6:0] SSD_SIX   = 7'b1011111;
  localparam logic [6:0] SSD_SEVEN = 7'b1110000;
  localparam logic [6:0] SSD_EIGHT = 7'b1111111;
  localparam logic [6:0] SSD_NINE  = 7'b1111011;

  localparam logic [3:0] SSD_ILLEGAL = 4'hF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  // Tens of seconds/minutes, hour tens, and hour units when hour tens is 2.
  localparam logic [3:0] LIM_TENS   = 4'd5;
  localparam logic [3:0] LIM_HOUR_H = 4'd2;
  localparam logic [3:0] LIM_HOUR_L = 4'd3;

endpackage

// File: rtl/ssd_glyph_dec.sv
// ssd_glyph_dec: combinational seven-segment to BCD decoder.
//   seg     in  7  segment pattern (bit6 = a ... bit0 = g)
//   digit   out 4  decoded digit, SSD_ILLEGAL for any non-digit pattern
//   illegal out 1  pattern is not one of the ten digit glyphs
module ssd_glyph_dec
  import ssd_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       illegal
);

  // Pattern match against the ten legal glyphs.
  always_comb begin
    digit   = SSD_ILLEGAL;
    illegal = 1'b1;
    case (seg)
      SSD_ZERO:  begin digit = 4'd0; illegal = 1'b0; end
      SSD_ONE:   begin digit = 4'd1; illegal = 1'b0; end
      SSD_TWO:   begin digit = 4'd2; illegal = 1'b0; end
      SSD_THREE: begin digit = 4'd3; illegal = 1'b0; end
      SSD_FOUR:  begin digit = 4'd4; illegal = 1'b0; end
      SSD_FIVE:  begin digit = 4'd5; illegal = 1'b0; end
      SSD_SIX:   begin digit = 4'd6; illegal = 1'b0; end
      SSD_SEVEN: begin digit = 4'd7; illegal = 1'b0; end
      SSD_EIGHT: begin digit = 4'd8; illegal = 1'b0; end
      SSD_NINE:  begin digit = 4'd9; illegal = 1'b0; end
      default:   begin digit = SSD_ILLEGAL; illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/ssd_time_monitor.sv
// ssd_time_monitor: receive-side checker for a seven-digit segment timer.
//   clk, rst_n        clock, asynchronous active-low reset
//   clr_err           synchronous clear of the sticky seq_err
//   ssd_*             seven segment buses (day, hh, hl, mh, ml, sh, sl)
//   bcd_time          decoded digits {day,hh,hl,mh,ml,sh,sl}
//   time_vld          last frame was legal
//   tick              pulse: frame is exactly one second after the previous
//   glyph_err         pulse: some bus carries a non-digit pattern
//   range_err         pulse: a legal glyph is out of range for its position
//   seq_err           sticky: time jumped to something other than +1 s
//   locked            monitor is in LOCK
//   elapsed_sec       saturating count of confirmed ticks
// Two stages: stage 1 captures the buses, stage 2 decodes, checks and
// registers every output.
module ssd_time_monitor
  import ssd_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int DAY_MAX = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_err,
  input  logic [6:0]       ssd_day,
  input  logic [6:0]       ssd_hour_h,
  input  logic [6:0]       ssd_hour_l,
  input  logic [6:0]       ssd_min_h,
  input  logic [6:0]       ssd_min_l,
  input  logic [6:0]       ssd_sec_h,
  input  logic [6:0]       ssd_sec_l,
  output logic [27:0]      bcd_time,
  output logic             time_vld,
  output logic             tick,
  output logic             glyph_err,
  output logic             range_err,
  output logic             seq_err,
  output logic             locked,
  output logic [CNT_W-1:0] elapsed_sec
);

  localparam logic [3:0] DAY_MAX_L = 4'(DAY_MAX);

  // +1 s increment with every carry applied; day wraps at DAY_MAX.
  function automatic logic [27:0] succ_time(input logic [27:0] t);
    logic [3:0] dy, hh, hl, mh, ml, sh, sl;
    logic       c;
    {dy, hh, hl, mh, ml, sh, sl} = t;
    if (sl == 4'd9) begin sl = 4'd0; c = 1'b1; end
    else begin sl = sl + 4'd1; c = 1'b0; end
    if (c) begin
      if (sh == LIM_TENS) begin sh = 4'd0; c = 1'b1; end
      else begin sh = sh + 4'd1; c = 1'b0; end
    end else begin
      c = 1'b0;
    end
    if (c) begin
      if (ml == 4'd9) begin ml = 4'd0; c = 1'b1; end
      else begin ml = ml + 4'd1; c = 1'b0; end
    end else begin
      c = 1'b0;
    end
    if (c) begin
      if (mh == LIM_TENS) begin mh = 4'd0; c = 1'b1; end
      else begin mh = mh + 4'd1; c = 1'b0; end
    end else begin
      c = 1'b0;
    end
    // Hours run 00..23; 23 rolls to 00 and carries into the day.
    if (c) begin
      if (hh == LIM_HOUR_H && hl == LIM_HOUR_L) begin hh = 4'd0; hl = 4'd0; c = 1'b1; end
      else if (hl == 4'd9) begin hl = 4'd0; hh = hh + 4'd1; c = 1'b0; end
      else begin hl = hl + 4'd1; c = 1'b0; end
    end else begin
      c = 1'b0;
    end
    if (c) begin
      if (dy == DAY_MAX_L) dy = 4'd0;
      else dy = dy + 4'd1;
    end else begin
      dy = dy;
    end
    return {dy, hh, hl, mh, ml, sh, sl};
  endfunction

  logic [48:0]      cap_d, cap_q;
  logic             cap_vld_d, cap_vld_q;
  logic [3:0]       dig_s [7];
  logic [6:0]       ill_s;
  logic [27:0]      frame_s, succ_p_s;
  logic             any_ill_s, rng_s, legal_s, seq_det_s;
  logic [1:0]       state_d, state_q;
  logic [27:0]      p_d, p_q;
  logic [27:0]      bcd_time_d, bcd_time_q;
  logic             time_vld_d, time_vld_q;
  logic             tick_d, tick_q;
  logic             glyph_err_d, glyph_err_q;
  logic             range_err_d, range_err_q;
  logic             seq_err_d, seq_err_q;
  logic             locked_d, locked_q;
  logic [CNT_W-1:0] elapsed_d, elapsed_q;

  // Stage 1 capture; cap_vld marks that a real frame has been sampled since
  // reset, so the cleared capture register is never judged as a bad frame.
  always_comb begin
    cap_d     = {ssd_day, ssd_hour_h, ssd_hour_l, ssd_min_h, ssd_min_l, ssd_sec_h, ssd_sec_l};
    cap_vld_d = 1'b1;
  end

  for (genvar gi = 0; gi < 7; gi++) begin : g_dec
    ssd_glyph_dec u_dec (
      .seg     (cap_q[gi*7 +: 7]),
      .digit   (dig_s[gi]),
      .illegal (ill_s[gi])
    );
  end

  // Range checks only apply to digits whose glyph decoded cleanly.
  always_comb begin
    frame_s   = {dig_s[6], dig_s[5], dig_s[4], dig_s[3], dig_s[2], dig_s[1], dig_s[0]};
    any_ill_s = |ill_s;
    rng_s     = (!ill_s[1] && (dig_s[1] > LIM_TENS))
              | (!ill_s[3] && (dig_s[3] > LIM_TENS))
              | (!ill_s[5] && (dig_s[5] > LIM_HOUR_H))
              | (!ill_s[5] && !ill_s[4] && (dig_s[5] == LIM_HOUR_H) && (dig_s[4] > LIM_HOUR_L))
              | (!ill_s[6] && (dig_s[6] > DAY_MAX_L));
    legal_s   = !any_ill_s && !rng_s;
    succ_p_s  = succ_time(p_q);
  end

  // Stage 2: state machine, prev-frame tracking, flags and tick counter.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    bcd_time_d  = bcd_time_q;
    time_vld_d  = time_vld_q;
    tick_d      = 1'b0;
    glyph_err_d = 1'b0;
    range_err_d = 1'b0;
    seq_det_s   = 1'b0;
    if (cap_vld_q) begin
      bcd_time_d  = frame_s;
      time_vld_d  = legal_s;
      glyph_err_d = any_ill_s;
      range_err_d = rng_s;
      if (!legal_s) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            p_d     = frame_s;
            state_d = ST_LOCK;
          end
          ST_LOCK, ST_FAULT: begin
            if (frame_s == p_q) begin
              p_d = p_q;
            end else if (frame_s == succ_p_s) begin
              tick_d = 1'b1;
              p_d    = frame_s;
            end else begin
              seq_det_s = 1'b1;
              p_d       = frame_s;
              state_d   = ST_FAULT;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else begin
      state_d = state_q;
    end
    // A fresh detection on the same edge beats the clear.
    if (seq_det_s) seq_err_d = 1'b1;
    else if (clr_err) seq_err_d = 1'b0;
    else seq_err_d = seq_err_q;
    if (state_d == ST_FAULT && !seq_det_s && clr_err) state_d = ST_LOCK;
    else state_d = state_d;
    if (tick_d && (elapsed_q != {CNT_W{1'b1}})) elapsed_d = elapsed_q + {{(CNT_W-1){1'b0}}, 1'b1};
    else elapsed_d = elapsed_q;
    locked_d = (state_d == ST_LOCK);
  end

  // All pipeline state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q       <= 49'd0;
      cap_vld_q   <= 1'b0;
      state_q     <= ST_IDLE;
      p_q         <= 28'd0;
      bcd_time_q  <= 28'd0;
      time_vld_q  <= 1'b0;
      tick_q      <= 1'b0;
      glyph_err_q <= 1'b0;
      range_err_q <= 1'b0;
      seq_err_q   <= 1'b0;
      locked_q    <= 1'b0;
      elapsed_q   <= {CNT_W{1'b0}};
    end else begin
      cap_q       <= cap_d;
      cap_vld_q   <= cap_vld_d;
      state_q     <= state_d;
      p_q         <= p_d;
      bcd_time_q  <= bcd_time_d;
      time_vld_q  <= time_vld_d;
      tick_q      <= tick_d;
      glyph_err_q <= glyph_err_d;
      range_err_q <= range_err_d;
      seq_err_q   <= seq_err_d;
      locked_q    <= locked_d;
      elapsed_q   <= elapsed_d;
    end
  end

  assign bcd_time    = bcd_time_q;
  assign time_vld    = time_vld_q;
  assign tick        = tick_q;
  assign glyph_err   = glyph_err_q;
  assign range_err   = range_err_q;
  assign seq_err     = seq_err_q;
  assign locked      = locked_q;
  assign elapsed_sec = elapsed_q;

endmodule

// File: tb/tb_ssd_time_monitor.sv
// tb_ssd_time_monitor: table-driven self-checking bench for ssd_time_monitor.
// Each table row is one frame plus the outputs expected once that frame has
// passed through both stages; rows are queued when driven and compared two
// cycles later.
module tb_ssd_time_monitor;

  typedef struct {
    logic [27:0] t;
    logic        bad;
    logic        clr;
    logic        tk, ge, re, vl, lk, se;
    logic [31:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_err = 1'b0;
  logic [6:0]  ssd_day, ssd_hour_h, ssd_hour_l, ssd_min_h, ssd_min_l, ssd_sec_h, ssd_sec_l;
  logic [27:0] bcd_time, s_bcd_time;
  logic        time_vld, tick, glyph_err, range_err, seq_err, locked;
  logic        s_time_vld, s_tick, s_glyph_err, s_range_err, s_seq_err, s_locked;
  logic [31:0] elapsed_sec;
  logic [1:0]  s_elapsed_sec;

  int total = 0;
  int bad = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  ssd_time_monitor #(.CNT_W(32), .DAY_MAX(9)) dut (
    .clk(clk), .rst_n(rst_n), .clr_err(clr_err),
    .ssd_day(ssd_day), .ssd_hour_h(ssd_hour_h), .ssd_hour_l(ssd_hour_l),
    .ssd_min_h(ssd_min_h), .ssd_min_l(ssd_min_l), .ssd_sec_h(ssd_sec_h), .ssd_sec_l(ssd_sec_l),
    .bcd_time(bcd_time), .time_vld(time_vld), .tick(tick), .glyph_err(glyph_err),
    .range_err(range_err), .seq_err(seq_err), .locked(locked), .elapsed_sec(elapsed_sec)
  );

  // Narrow counter copy on the same buses, used only to see saturation.
  ssd_time_monitor #(.CNT_W(2), .DAY_MAX(9)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clr_err(clr_err),
    .ssd_day(ssd_day), .ssd_hour_h(ssd_hour_h), .ssd_hour_l(ssd_hour_l),
    .ssd_min_h(ssd_min_h), .ssd_min_l(ssd_min_l), .ssd_sec_h(ssd_sec_h), .ssd_sec_l(ssd_sec_l),
    .bcd_time(s_bcd_time), .time_vld(s_time_vld), .tick(s_tick), .glyph_err(s_glyph_err),
    .range_err(s_range_err), .seq_err(s_seq_err), .locked(s_locked), .elapsed_sec(s_elapsed_sec)
  );

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic add(input logic [27:0] t, input logic b, input logic c,
                     input logic tk, input logic ge, input logic re, input logic vl,
                     input logic lk, input logic se, input int cnt);
    vec_t v;
    v.t = t; v.bad = b; v.clr = c;
    v.tk = tk; v.ge = ge; v.re = re; v.vl = vl; v.lk = lk; v.se = se;
    v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic drive_frame(input logic [27:0] t, input logic b);
    ssd_day    = enc(t[27:24]);
    ssd_hour_h = enc(t[23:20]);
    ssd_hour_l = enc(t[19:16]);
    ssd_min_h  = enc(t[15:12]);
    ssd_min_l  = b ? 7'b0000001 : enc(t[11:8]);
    ssd_sec_h  = enc(t[7:4]);
    ssd_sec_l  = enc(t[3:0]);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bcd"}, {4'd0, bcd_time}, 32'd0);
    chk({tag, "_vld"}, {31'd0, time_vld}, 32'd0);
    chk({tag, "_tick"}, {31'd0, tick}, 32'd0);
    chk({tag, "_glyph"}, {31'd0, glyph_err}, 32'd0);
    chk({tag, "_range"}, {31'd0, range_err}, 32'd0);
    chk({tag, "_seq"}, {31'd0, seq_err}, 32'd0);
    chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
    chk({tag, "_cnt"}, elapsed_sec, 32'd0);
  endtask

  task automatic cmp(input int idx, input vec_t e);
    logic [27:0] eb;
    string p;
    p  = $sformatf("v%0d", idx);
    eb = e.bad ? {e.t[27:12], 4'hF, e.t[7:0]} : e.t;
    chk({p, "_bcd"}, {4'd0, bcd_time}, {4'd0, eb});
    chk({p, "_vld"}, {31'd0, time_vld}, {31'd0, e.vl});
    chk({p, "_tick"}, {31'd0, tick}, {31'd0, e.tk});
    chk({p, "_glyph"}, {31'd0, glyph_err}, {31'd0, e.ge});
    chk({p, "_range"}, {31'd0, range_err}, {31'd0, e.re});
    chk({p, "_seq"}, {31'd0, seq_err}, {31'd0, e.se});
    chk({p, "_locked"}, {31'd0, locked}, {31'd0, e.lk});
    chk({p, "_cnt"}, elapsed_sec, e.cnt);
  endtask

  // clr_err acts one stage earlier than the frame path, so a row's clear is
  // driven one cycle after its frame to land on the same stage-2 edge.
  task automatic run_seg(input int first, input int last);
    for (int j = first; j <= last + 2; j++) begin
      @(negedge clk);
      if (j >= first + 2) cmp(j - 2, exp_q.pop_front());
      if (j <= last) begin
        drive_frame(vecs[j].t, vecs[j].bad);
        clr_err = (j > first) ? vecs[j-1].clr : 1'b0;
        exp_q.push_back(vecs[j]);
      end else begin
        clr_err = (j == last + 1) ? vecs[last].clr : 1'b0;
      end
    end
  endtask

  initial begin
    //   time          bad  clr  tk ge re vl lk se cnt
    add(28'h0000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0); // 0 lock
    add(28'h0000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    add(28'h0000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    add(28'h0000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0); // 3 bad glyph
    add(28'h3235958, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0); // 4 relock
    add(28'h3235959, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    add(28'h4000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2); // 6 day carry
    add(28'h4240000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2); // 7 hour 24
    add(28'h1101530, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2); // 8 lock
    add(28'h1101532, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2); // 9 skip
    add(28'h1101533, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3); // 10 tick in FAULT
    add(28'h1101533, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3); // 11 clear
    add(28'h1101534, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4);
    add(28'h1101540, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4); // 13 clr vs detect
    add(28'h1101540, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4); // 14 sticky in IDLE
    add(28'h9235959, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4);
    add(28'h0000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5); // 16 day wrap
    add(28'h0000001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6);
    add(28'h0000060, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6); // 18 sec_h 6
    add(28'h0000101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6);
    // after a mid-stream reset
    add(28'h0000002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0); // 20
    add(28'h0000002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    add(28'h0000003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);

    drive_frame(vecs[0].t, 1'b0);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    run_seg(0, 19);

    chk("sat_cnt", {30'd0, s_elapsed_sec}, 32'd3);

    // Asynchronous reset away from any clock edge.
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    drive_frame(vecs[20].t, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_seg(20, 22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
